mrv32_mem_arb: RTL and testbench

Two-master arbiter that shares the single-port RAM bus (b_valid/b_addr/b_wdata/b_wstrb/b_rdata/b_rvalid) between the instruction-fetch unit (master 0, read-only) and the load/store unit (master 1, read/write). It grants one transaction at a time using round-robin priority and tracks the single outstanding read. It returns each read response to the master that issued it, and it recovers from a bus that never answers by using a response timeout.

---
 rtl/mrv32_pkg.sv | 24 ++
 rtl/mrv32_rr_pick2.sv | 21 ++
 rtl/mrv32_mem_arb.sv | 181 ++++++++++++++++++
 tb/tb_mrv32_mem_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrv32_pkg.sv
// mrv32_pkg: shared widths, strobe encodings and memory-arbiter types.
package mrv32_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // An all-zero strobe marks a read command on the RAM bus.
  localparam logic [STRB_WIDTH-1:0] WSTRB_NONE = '0;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mrv32_rr_pick2.sv
// mrv32_rr_pick2: combinational two-way round-robin picker.
// Ports:
//   req[1:0] - request per master
//   last     - master granted most recently (0 = M0, 1 = M1)
//   gnt[1:0] - one-hot (or zero) grant
module mrv32_rr_pick2
  import mrv32_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the master that did not win last time goes first.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | (last == M1));
    gnt[1] = req[1] & (~req[0] | (last == M0));
  end

endmodule

// File: rtl/mrv32_mem_arb.sv
// mrv32_mem_arb: shares the single-port RAM bus between instruction fetch
// (master 0, reads only) and the load/store unit (master 1, reads/writes).
// One command per grant, at most one read outstanding, round-robin on ties.
// Read responses are routed to the issuing master; a read the bus never
// answers is failed with err after TIMEOUT_CYCLES, and the late response
// (if any) is swallowed in FLUSH.
// Ports:
//   clk, rst                         - clock, async active-high reset
//   m0_req/m0_addr -> m0_gnt         - fetch request / accept
//   m0_rvalid/m0_rdata/m0_err        - fetch response
//   m1_req/m1_addr/m1_wdata/m1_wstrb -> m1_gnt - LSU request / accept
//   m1_rvalid/m1_rdata/m1_err        - LSU read response
//   b_valid/b_addr/b_wdata/b_wstrb   - bus command
//   b_rdata/b_rvalid                 - bus read response
//   busy                             - a read is outstanding or being flushed
module mrv32_mem_arb #(
  parameter int unsigned ADDR_WIDTH     = mrv32_pkg::ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = mrv32_pkg::ARB_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  m1_err,
  output logic                  b_valid,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [31:0]           b_wdata,
  output logic [3:0]            b_wstrb,
  input  logic [31:0]           b_rdata,
  input  logic                  b_rvalid,
  output logic                  busy
);

  import mrv32_pkg::*;

  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  arb_owner_t       last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [1:0]  pick_gnt;
  logic        resp_valid;
  logic        resp_err;

  mrv32_rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .gnt  (pick_gnt)
  );

  // Next-state, counter and response-event logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_gnt[1]) begin
          last_d = M1;
          if (m1_wstrb == WSTRB_NONE) begin
            state_d = WAIT;
            owner_d = M1;
            cnt_d   = '0;
          end
        end else if (pick_gnt[0]) begin
          last_d  = M0;
          state_d = WAIT;
          owner_d = M0;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (b_rvalid) begin
          resp_valid = 1'b1;
          state_d    = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          state_d    = FLUSH;
          cnt_d      = '0;
        end else if (TO_EN && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FLUSH: begin
        // Swallow the late response so it cannot answer the next read.
        if (b_rvalid || (TO_EN && (cnt_q == CNT_LAST))) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (TO_EN && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Grant/command muxing and response routing; everything forced low in reset.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    b_valid   = 1'b0;
    b_addr    = '0;
    b_wdata   = '0;
    b_wstrb   = WSTRB_NONE;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      if (state_q == IDLE) begin
        if (pick_gnt[1]) begin
          m1_gnt  = 1'b1;
          b_valid = 1'b1;
          b_addr  = m1_addr;
          b_wdata = m1_wdata;
          b_wstrb = m1_wstrb;
        end else if (pick_gnt[0]) begin
          m0_gnt  = 1'b1;
          b_valid = 1'b1;
          b_addr  = m0_addr;
        end
      end
      if (resp_valid) begin
        if (owner_q == M0) begin
          m0_rvalid = 1'b1;
          m0_err    = resp_err;
          m0_rdata  = resp_err ? 32'h0 : b_rdata;
        end else begin
          m1_rvalid = 1'b1;
          m1_err    = resp_err;
          m1_rdata  = resp_err ? 32'h0 : b_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= M0;
      last_q  <= M0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mrv32_mem_arb.sv
// tb_mrv32_mem_arb: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_mrv32_mem_arb;

  localparam int unsigned AW = mrv32_pkg::ADDR_WIDTH;
  localparam int          TO = 4;

  logic          clk;
  logic          rst;
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt, m0_rvalid, m0_err;
  logic [31:0]   m0_rdata;
  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic [3:0]    m1_wstrb;
  logic          m1_gnt, m1_rvalid, m1_err;
  logic [31:0]   m1_rdata;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata;
  logic [3:0]    b_wstrb;
  logic [31:0]   b_rdata;
  logic          b_rvalid;
  logic          busy;

  mrv32_mem_arb #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_wstrb   (b_wstrb),
    .b_rdata   (b_rdata),
    .b_rvalid  (b_rvalid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: an outstanding read (who, how long), a flush in progress
  // (how long), and who won the last grant.
  bit md_pend, md_flush;
  int md_age, md_fage, md_owner, md_last;
  bit nx_pend, nx_flush;
  int nx_age, nx_fage, nx_owner, nx_last;

  logic          e_g0, e_g1, e_rv0, e_rv1, e_err0, e_err1, e_bv, e_busy;
  logic [31:0]   e_rd0, e_rd1, e_wd;
  logic [AW-1:0] e_ba;
  logic [3:0]    e_ws;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_eval();
    int w;
    e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0;
    e_bv = 0; e_busy = 0; e_rd0 = '0; e_rd1 = '0; e_wd = '0; e_ba = '0; e_ws = '0;
    nx_pend = md_pend; nx_flush = md_flush; nx_age = md_age; nx_fage = md_fage;
    nx_owner = md_owner; nx_last = md_last;
    if (rst) begin
      nx_pend = 0; nx_flush = 0; nx_age = 0; nx_fage = 0; nx_owner = 0; nx_last = 0;
      return;
    end
    e_busy = md_pend || md_flush;
    if (md_pend) begin
      if (b_rvalid) begin
        if (md_owner == 0) begin e_rv0 = 1; e_rd0 = b_rdata; end
        else               begin e_rv1 = 1; e_rd1 = b_rdata; end
        nx_pend = 0;
      end else if (TO > 0 && md_age == TO - 1) begin
        if (md_owner == 0) begin e_rv0 = 1; e_err0 = 1; end
        else               begin e_rv1 = 1; e_err1 = 1; end
        nx_pend = 0; nx_flush = 1; nx_fage = 0;
      end else begin
        nx_age = md_age + 1;
      end
    end else if (md_flush) begin
      if (b_rvalid || md_fage == TO - 1) nx_flush = 0;
      else nx_fage = md_fage + 1;
    end else begin
      w = -1;
      if (m0_req && m1_req) w = (md_last == 1) ? 0 : 1;
      else if (m0_req)      w = 0;
      else if (m1_req)      w = 1;
      if (w == 0) begin
        e_g0 = 1; e_bv = 1; e_ba = m0_addr;
        nx_last = 0; nx_pend = 1; nx_owner = 0; nx_age = 0;
      end else if (w == 1) begin
        e_g1 = 1; e_bv = 1; e_ba = m1_addr; e_wd = m1_wdata; e_ws = m1_wstrb;
        nx_last = 1;
        if (m1_wstrb == 4'h0) begin nx_pend = 1; nx_owner = 1; nx_age = 0; end
      end
    end
  endtask

  // Check one cycle's outputs against the model, then advance a clock.
  task automatic step();
    #1;
    model_eval();
    chk("m0_gnt",    64'(m0_gnt),    64'(e_g0));
    chk("m1_gnt",    64'(m1_gnt),    64'(e_g1));
    chk("b_valid",   64'(b_valid),   64'(e_bv));
    if (e_bv || rst) begin
      chk("b_addr",  64'(b_addr),    64'(e_ba));
      chk("b_wdata", 64'(b_wdata),   64'(e_wd));
      chk("b_wstrb", 64'(b_wstrb),   64'(e_ws));
    end
    chk("m0_rvalid", 64'(m0_rvalid), 64'(e_rv0));
    chk("m1_rvalid", 64'(m1_rvalid), 64'(e_rv1));
    chk("m0_err",    64'(m0_err),    64'(e_err0));
    chk("m1_err",    64'(m1_err),    64'(e_err1));
    chk("m0_rdata",  64'(m0_rdata),  64'(e_rd0));
    chk("m1_rdata",  64'(m1_rdata),  64'(e_rd1));
    chk("busy",      64'(busy),      64'(e_busy));
    @(posedge clk);
    md_pend = nx_pend; md_flush = nx_flush; md_age = nx_age; md_fage = nx_fage;
    md_owner = nx_owner; md_last = nx_last;
    #1;
  endtask

  initial begin
    int wi;
    logic resp;
    logic g0p, g1p;
    int r;
    md_pend = 0; md_flush = 0; md_age = 0; md_fage = 0; md_owner = 0; md_last = 0;
    rst = 1'b1;
    m0_req = 1; m0_addr = AW'(32'h10);
    m1_req = 1; m1_addr = AW'(32'h20); m1_wdata = 32'h0; m1_wstrb = 4'h0;
    b_rvalid = 1; b_rdata = 32'h12345678;
    step();                       // all outputs low in reset despite activity
    b_rvalid = 0;
    step();
    rst = 1'b0;

    // Tie after reset: M1 first, bus answers next cycle, then M0.
    step();                       // m1_gnt, b_addr=0x20
    m1_req = 0; b_rvalid = 1; b_rdata = 32'hDEADBEEF;
    step();                       // m1_rvalid with DEADBEEF
    b_rvalid = 0;
    step();                       // m0_gnt
    m0_req = 0;
    step();
    b_rvalid = 1; b_rdata = 32'hCAFEF00D;
    step();
    b_rvalid = 0;

    // Back-to-back writes from M1 against a continuously requesting M0.
    m0_req = 1; m0_addr = AW'(32'h44);
    m1_req = 1; m1_addr = AW'(32'h0); m1_wdata = 32'h11111111; m1_wstrb = 4'hF;
    wi = 0; resp = 0;
    for (int k = 0; k < 16 && wi < 3; k++) begin
      b_rvalid = resp; b_rdata = 32'hA5A50000 + 32'(k);
      step();
      resp = e_g0;
      if (e_g1) begin
        wi++;
        m1_addr = AW'(4 * wi); m1_wdata = 32'h11111111 * 32'(wi + 1);
        if (wi == 3) m1_req = 0;
      end
    end
    m0_req = 0; b_rvalid = resp; b_rdata = 32'h0BADC0DE;
    step();
    b_rvalid = 0;
    step();

    // M0 read answered on the last cycle before timeout, M1 held off.
    m0_req = 1; m0_addr = AW'(32'h80);
    step();                       // m0_gnt
    m0_req = 0; m1_req = 1; m1_addr = AW'(32'h84); m1_wstrb = 4'h0;
    step(); step(); step();
    b_rvalid = 1; b_rdata = 32'h5A5A5A5A;
    step();                       // response beats the timeout
    b_rvalid = 0;

    // M1 read with no answer: error, then late response discarded.
    step();                       // m1_gnt
    m1_req = 0;
    step(); step(); step(); step(); // fourth WAIT cycle -> m1_err
    step(); step();
    b_rvalid = 1; b_rdata = 32'h77777777;
    step();                       // swallowed in FLUSH
    b_rvalid = 0;
    m0_req = 1; m0_addr = AW'(32'h90);
    step();
    m0_req = 0; b_rvalid = 1; b_rdata = 32'h90909090;
    step();

    // Stray response while idle.
    b_rdata = 32'hFFFF0000;
    step();
    b_rvalid = 0;

    // Flush that expires without any late response.
    m1_req = 1; m1_addr = AW'(32'hC0); m1_wstrb = 4'h0;
    step();
    m1_req = 0;
    for (int k = 0; k < 10; k++) step();

    // Async reset while WAIT, with a response on the bus.
    m0_req = 1; m0_addr = AW'(32'hA0);
    step();
    m0_req = 0;
    step();
    rst = 1'b1; b_rvalid = 1; b_rdata = 32'h13131313;
    step();
    b_rvalid = 0; m0_req = 1; m1_req = 1; m1_wstrb = 4'h0;
    m0_addr = AW'(32'h10); m1_addr = AW'(32'h20);
    step();
    rst = 1'b0;
    step();                       // tie goes to M1 again
    m0_req = 0; m1_req = 0; b_rvalid = 1; b_rdata = 32'h24242424;
    step();
    b_rvalid = 0;

    // Random traffic.
    g0p = 1; g1p = 1;
    for (int i = 0; i < 600; i++) begin
      if (!m0_req || g0p) begin
        m0_req = ($urandom % 3) != 0;
        m0_addr = AW'($urandom);
      end
      if (!m1_req || g1p) begin
        m1_req = ($urandom % 3) != 0;
        m1_addr = AW'($urandom);
        m1_wdata = $urandom;
        r = int'($urandom % 3);
        m1_wstrb = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : 4'($urandom);
      end
      if (md_pend || md_flush) b_rvalid = ($urandom % 4) == 0;
      else                     b_rvalid = ($urandom % 10) == 0;
      b_rdata = $urandom;
      step();
      g0p = e_g0; g1p = e_g1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
